// File: rtl/stereo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stereo_pkg
//  Description : Shared types and widths for the stereo-distance datapath
//                (cost producer and min-selection comparator).
//  Revision    : 1.0 - initial release
// ============================================================================
package stereo_pkg;

    localparam int COST_W = 18;
    localparam int DISP_W = 6;

    typedef logic [COST_W-1:0] cost_t;
    typedef logic [DISP_W-1:0] disp_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DRAIN  = 3'd2,
        EMIT   = 3'd3,
        FINISH = 3'd4
    } sad_state_t;

endpackage
`default_nettype wire

// File: rtl/abs_diff.sv
`default_nettype none
// ============================================================================
//  Module      : abs_diff
//  Description : Combinational absolute difference |a - b| of two unsigned
//                W-bit operands. The result always fits in W bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_diff #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    // Subtract the smaller from the larger so no sign bit is ever needed
    always_comb begin
        y = (a >= b) ? (a - b) : (b - a);
    end

endmodule
`default_nettype wire

// File: rtl/sad_cost_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sad_cost_gen
//  Description : Sum-of-absolute-differences cost producer. For one reference
//                window it sweeps disparity 0..MAX_DISP-1, reads WIN_PIX
//                left/right pixel pairs per disparity from the line buffer
//                (1-cycle read latency) and emits (cost, disparity) pairs over
//                a valid/ready handshake.
//  Options     : SAD_COST_SAT_EN - when defined the accumulator saturates at
//                all-ones instead of wrapping modulo 2^COST_W.
//  Revision    : 1.0 - initial release
// ============================================================================
module sad_cost_gen #(
    parameter  int PIX_W    = 8,
    parameter  int WIN_PIX  = 1024,
    parameter  int MAX_DISP = 64,
    parameter  int COST_W   = 18,
    localparam int IDX_W    = (WIN_PIX > 1) ? $clog2(WIN_PIX) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  rd_en,
    output logic [IDX_W-1:0]      rd_idx,
    output stereo_pkg::disp_t     rd_disp,
    input  logic [PIX_W-1:0]      rd_left,
    input  logic [PIX_W-1:0]      rd_right,
    output logic [COST_W-1:0]     cost_out,
    output stereo_pkg::disp_t     disp_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    import stereo_pkg::*;

    sad_state_t          state;
    sad_state_t          state_nxt;
    logic                pix_vld;      // rd_left/rd_right carry a pair this cycle
    logic [COST_W-1:0]   acc;
    logic [COST_W-1:0]   acc_nxt;
    logic [PIX_W-1:0]    pix_diff;
    logic [COST_W-1:0]   diff_ext;
    logic                last_idx;
    logic                last_disp;

    abs_diff #(
        .W (PIX_W)
    ) u_abs_diff (
        .a (rd_left),
        .b (rd_right),
        .y (pix_diff)
    );

    // Only pairs requested in the previous cycle contribute to the sum
    assign diff_ext  = pix_vld ? COST_W'(pix_diff) : '0;
    assign last_idx  = (rd_idx == IDX_W'(WIN_PIX - 1));
    assign last_disp = (rd_disp == DISP_W'(MAX_DISP - 1));

`ifdef SAD_COST_SAT_EN
    logic [COST_W:0] sum_wide;

    // Clamp to all-ones on carry-out; once there, every later add clamps again
    always_comb begin
        sum_wide = {1'b0, acc} + {1'b0, diff_ext};
        acc_nxt  = sum_wide[COST_W] ? '1 : sum_wide[COST_W-1:0];
    end
`else
    // Plain modulo-2^COST_W accumulation
    always_comb begin
        acc_nxt = acc + diff_ext;
    end
`endif

    // Status outputs decode directly from the state register
    always_comb begin
        rd_en = (state == FETCH);
        busy  = (state != IDLE);
        done  = (state == FINISH);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = FETCH;
            FETCH:   if (last_idx)  state_nxt = DRAIN;
            DRAIN:                  state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_disp ? FINISH : FETCH;
            FINISH:                 state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Read addressing, accumulation and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx    <= '0;
            rd_disp   <= '0;
            cost_out  <= '0;
            disp_out  <= '0;
            out_valid <= 1'b0;
            acc       <= '0;
            pix_vld   <= 1'b0;
        end else begin
            pix_vld <= (state == FETCH);
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_idx  <= '0;
                        rd_disp <= '0;
                        acc     <= '0;
                    end
                end
                FETCH: begin
                    acc    <= acc_nxt;
                    rd_idx <= last_idx ? '0 : rd_idx + 1'b1;
                end
                DRAIN: begin
                    // acc_nxt folds in the final pair returned this cycle
                    cost_out  <= acc_nxt;
                    disp_out  <= rd_disp;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!last_disp) begin
                            rd_disp <= rd_disp + 1'b1;
                            rd_idx  <= '0;
                            acc     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sad_cost_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sad_cost_gen
//  Description : Self-checking bench for sad_cost_gen with a line-buffer model
//                and an expected-result queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sad_cost_gen;

    localparam int WIN  = 1024;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rd_en;
    logic [9:0]  rd_idx;
    logic [5:0]  rd_disp;
    logic [7:0]  rd_left;
    logic [7:0]  rd_right;
    logic [17:0] cost_out;
    logic [5:0]  disp_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    // second instance: long window for the overflow behaviour
    logic        start2;
    logic        rd_en2;
    logic [10:0] rd_idx2;
    logic [5:0]  rd_disp2;
    logic [7:0]  rd_left2;
    logic [7:0]  rd_right2;
    logic [17:0] cost_out2;
    logic [5:0]  disp_out2;
    logic        out_valid2;
    logic        out_ready2;
    logic        busy2;
    logic        done2;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          mode    = 0;
    int          done_cnt = 0;
    logic [23:0] sb_q[$];

    always #5 clk = ~clk;

    sad_cost_gen #(.PIX_W(8), .WIN_PIX(WIN), .MAX_DISP(MAXD), .COST_W(18)) dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_idx(rd_idx),
        .rd_disp(rd_disp), .rd_left(rd_left), .rd_right(rd_right),
        .cost_out(cost_out), .disp_out(disp_out), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    sad_cost_gen #(.PIX_W(8), .WIN_PIX(1100), .MAX_DISP(1), .COST_W(18)) dut_sat (
        .clk(clk), .rst(rst), .start(start2), .rd_en(rd_en2), .rd_idx(rd_idx2),
        .rd_disp(rd_disp2), .rd_left(rd_left2), .rd_right(rd_right2),
        .cost_out(cost_out2), .disp_out(disp_out2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    function automatic int lpix(int m, int idx, int d);
        case (m)
            0:       return 10;
            1:       return 200;
            default: return idx & 255;
        endcase
    endfunction

    function automatic int rpix(int m, int idx, int d);
        case (m)
            0:       return 7;
            1:       return (d == 2) ? 200 : 195;
            default: return (3 * idx + 7 * d) & 255;
        endcase
    endfunction

    function automatic logic [17:0] exp_cost(int m, int d);
        int s = 0;
        for (int i = 0; i < WIN; i++) begin
            int l = lpix(m, i, d);
            int r = rpix(m, i, d);
            s += (l > r) ? (l - r) : (r - l);
        end
        return 18'(s);
    endfunction

    // line buffer: data returned one cycle after the request
    always @(posedge clk) begin
        if (rd_en) begin
            rd_left  <= 8'(lpix(mode, int'(rd_idx), int'(rd_disp)));
            rd_right <= 8'(rpix(mode, int'(rd_idx), int'(rd_disp)));
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // output monitor: pops the queue on every handshake, checks done timing
    initial begin
        logic prev_last;
        logic [23:0] e;
        prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0) begin
                prev_last = 1'b0;
            end else begin
                if (done === 1'b1) begin
                    done_cnt++;
                    chk("done_after_last_accept", 32'(prev_last), 1);
                end
                prev_last = 1'b0;
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("cost", 32'(cost_out), 32'(e[23:6]));
                        chk("disp", 32'(disp_out), 32'(e[5:0]));
                    end
                    prev_last = (disp_out == 6'(MAXD - 1));
                end
            end
        end
    end

    task automatic begin_sweep(input int m);
        mode = m;
        for (int d = 0; d < MAXD; d++) sb_q.push_back({exp_cost(m, d), 6'(d)});
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish_sweep(input int done_before);
        int n = 0;
        while (done !== 1'b1 && n < 20000) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 1);
        repeat (3) tick();
        chk("idle_after_sweep", 32'(busy), 0);
        chk("done_pulses", 32'(done_cnt - done_before), 1);
        chk("queue_empty", 32'(sb_q.size()), 0);
    endtask

    task automatic wait_out(input int d);
        int n = 0;
        while (!(out_valid === 1'b1 && disp_out == 6'(d)) && n < 20000) begin
            tick();
            n++;
        end
        chk("wait_out_valid", 32'(out_valid), 1);
    endtask

    initial begin
        int n;
        int dc;
        logic [17:0] held_cost;
        logic [5:0]  held_disp;

        rst = 1'b1; start = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; out_ready2 = 1'b1; rd_left2 = 8'd255; rd_right2 = 8'd0;
        repeat (3) tick();
        chk("rst_rd_en", 32'(rd_en), 0);
        chk("rst_rd_idx", 32'(rd_idx), 0);
        chk("rst_rd_disp", 32'(rd_disp), 0);
        chk("rst_cost", 32'(cost_out), 0);
        chk("rst_disp", 32'(disp_out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        tick();

        // constant 10/7 pattern, with first-result latency
        dc = done_cnt;
        begin_sweep(0);
        chk("first_rd_en", 32'(rd_en), 1);
        chk("first_rd_idx", 32'(rd_idx), 0);
        chk("first_busy", 32'(busy), 1);
        n = 0;
        while (out_valid !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
        chk("valid_latency", 32'(n), WIN + 1);
        finish_sweep(dc);

        // exact match at d=2 only
        dc = done_cnt;
        begin_sweep(1);
        finish_sweep(dc);

        // index-dependent data with 50 cycles of back-pressure at d=1
        dc = done_cnt;
        begin_sweep(2);
        wait_out(1);
        out_ready = 1'b0;
        held_cost = cost_out;
        held_disp = disp_out;
        repeat (50) begin
            tick();
            chk("hold_cost", 32'(cost_out), 32'(held_cost));
            chk("hold_disp", 32'(disp_out), 1);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_no_read", 32'(rd_en), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("release_valid_low", 32'(out_valid), 0);
        chk("release_fetch", 32'(rd_en), 1);
        chk("release_rd_disp", 32'(rd_disp), 2);
        chk("release_rd_idx", 32'(rd_idx), 0);
        finish_sweep(dc);

        // start pulsed while a result is pending
        dc = done_cnt;
        begin_sweep(0);
        wait_out(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_sweep(dc);

        // reset mid-FETCH at idx=500, d=3 abandons the sweep
        begin_sweep(1);
        n = 0;
        while (!(rd_idx == 10'd500 && rd_disp == 6'd3) && n < 20000) begin
            tick();
            n++;
        end
        chk("reached_idx500_d3", 32'(rd_en), 1);
        rst = 1'b1;
        sb_q.delete();
        tick();
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_rd_en", 32'(rd_en), 0);
        rst = 1'b0;
        repeat (1100) tick();
        chk("midrst_still_idle", 32'(busy), 0);
        dc = done_cnt;
        begin_sweep(2);
        finish_sweep(dc);

        // long window: 1100 * 255 overflows 18 bits
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (out_valid2 !== 1'b1 && n < 5000) begin
            tick();
            n++;
        end
`ifdef SAD_COST_SAT_EN
        chk("long_window_cost", 32'(cost_out2), 32'h3FFFF);
`else
        chk("long_window_cost", 32'(cost_out2), 18356);
`endif
        chk("long_window_disp", 32'(disp_out2), 0);
        tick();
        chk("long_window_done", 32'(done2), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
